// File: rtl/mul_div_int_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 opcodes and FSM states.
package mul_div_int_pkg;

    // RV32M funct3 encodings, shared with the decode stage
    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StFinish = 2'd2
    } md_state_e;

    function automatic logic op_is_div(md_op_e op);
        return op inside {MdDiv, MdDivu, MdRem, MdRemu};
    endfunction

    // rs1 is treated as signed
    function automatic logic op1_is_signed(md_op_e op);
        return op inside {MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    // rs2 is treated as signed
    function automatic logic op2_is_signed(md_op_e op);
        return op inside {MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Final result selection and sign correction for the multiply/divide unit.
// Input is the unsigned magnitude result: a 64-bit product, or {remainder, quotient}.
module mul_div_sign_fix
    import mul_div_int_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        md_op,
    input  logic [2*XLEN-1:0] raw,
    input  logic              neg_res,
    input  logic              neg_rem,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Apply sign correction and pick the word the opcode asks for
    always_comb begin
        prod   = neg_res ? -raw : raw;
        quot   = neg_res ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem    = neg_rem ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        result = '0;
        unique case (md_op_e'(md_op))
            MdMul:                     result = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: result = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             result = quot;
            MdRem, MdRemu:             result = rem;
            default:                   result = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_int.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one iteration per cycle, with a fast path for divide-by-zero and overflow.
module mul_div_int
    import mul_div_int_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Multiply: accumulator. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiply: shifting multiplicand. Divide: divisor in the low word.
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] step_mcand;
    logic [XLEN-1:0]   step_mplier;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   fix_result;

    md_op_e            op_in;
    logic              op1_neg, op2_neg;
    logic [XLEN-1:0]   op1_abs, op2_abs;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_result;

    // One iteration of the datapath, applied to the current registers
    always_comb begin
        trial       = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        step_acc    = acc_q;
        step_mcand  = mcand_q;
        step_mplier = mplier_q;
        if (op_is_div(op_q)) begin
            if (trial >= {1'b0, mcand_q[XLEN-1:0]}) begin
                step_acc = {trial[XLEN-1:0] - mcand_q[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                step_acc = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc    = acc_q + (mplier_q[0] ? mcand_q : '0);
            step_mcand  = mcand_q << 1;
            step_mplier = mplier_q >> 1;
        end
    end

    mul_div_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .md_op   (op_q),
        .raw     (step_acc),
        .neg_res (neg_res_q),
        .neg_rem (neg_rem_q),
        .result  (fix_result)
    );

    // Operand decode for a new request: magnitudes and the fast-path cases
    always_comb begin
        op_in    = md_op_e'(md_op);
        op1_neg  = op1[XLEN-1] && op1_is_signed(op_in);
        op2_neg  = op2[XLEN-1] && op2_is_signed(op_in);
        op1_abs  = op1_neg ? -op1 : op1;
        op2_abs  = op2_neg ? -op2 : op2;
        div_zero = op_is_div(op_in) && (op2 == '0);
        div_ovf  = (op_in inside {MdDiv, MdRem}) && (op1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (op2 == '1);
        fast_result = '0;
        if (div_zero) begin
            fast_result = (op_in inside {MdDiv, MdDivu}) ? '1 : op1;
        end else if (div_ovf) begin
            fast_result = (op_in == MdDiv) ? op1 : '0;
        end
    end

    // Next-state logic; DONE in the cycle after FINISH keeps START in that cycle ignored
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !done_q) begin
                    op_d      = op_in;
                    cnt_d     = '0;
                    neg_res_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    if (div_zero || div_ovf) begin
                        result_d = fast_result;
                        state_d  = StFinish;
                    end else begin
                        state_d = StCalc;
                        if (op_is_div(op_in)) begin
                            acc_d    = {{XLEN{1'b0}}, op1_abs};
                            mcand_d  = {{XLEN{1'b0}}, op2_abs};
                            mplier_d = '0;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{XLEN{1'b0}}, op1_abs};
                            mplier_d = op2_abs;
                        end
                    end
                end
            end
            StCalc: begin
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    result_d = fix_result;
                    state_d  = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle) || done_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= MdMul;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mul_div_int.sv
// Self-checking bench for mul_div_int: directed vector table plus corner sequences.
module tb_mul_div_int;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    mul_div_int dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .op1     (op1),
        .op2     (op2),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request for one edge, then scramble inputs to prove they are latched
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int s_edge);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        s_edge = edge_cnt;
        start  = 1'b0;
        md_op  = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
    endtask

    // Poll until DONE (bounded); BUSY must hold in every cycle up to and including DONE
    task automatic wait_done(input int s_edge, output logic [31:0] res, output int lat,
                             output bit busy_ok);
        busy_ok = 1'b1;
        lat     = -1;
        res     = '0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = edge_cnt - s_edge;
                res = result;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          s_edge;
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        issue(v.op, v.a, v.b, s_edge);
        wait_done(s_edge, res, lat, busy_ok);
        check({v.name, " result"}, res, v.res);
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " busy held"}, 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        check({v.name, " idle after done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Count DONE pulses over a window; nothing should complete
    task automatic expect_quiet(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int          s_edge;
        int          lat;
        logic [31:0] res;
        bit          busy_ok;

        vecs[0]  = '{"mul 7*-3",         3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulhu -1*-1",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{"mulh -1*-1",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{"mulhsu -1*2",      3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{"mulh min*min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[5]  = '{"mulhsu min*umax",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[6]  = '{"div -20/3",        3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33};
        vecs[7]  = '{"rem -20/3",        3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33};
        vecs[8]  = '{"divu 100/7",       3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[9]  = '{"remu 100/7",       3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[10] = '{"div 7/-2",         3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[11] = '{"rem 7/-2",         3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[12] = '{"remu umax/16",     3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33};
        vecs[13] = '{"div min/1",        3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33};
        vecs[14] = '{"divu 100/0",       3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[15] = '{"rem 100/0",        3'd6, 32'd100,       32'd0,         32'd100,       1};
        vecs[16] = '{"div min/-1",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[17] = '{"rem min/-1",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[18] = '{"div 100/0",        3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: each request follows the previous one in the cycle after DONE
        for (int i = 0; i < 19; i++) run_vec(vecs[i]);

        // START re-pulsed mid-CALC with a fast-path op must be ignored
        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, s_edge);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'd5;
        op1   = 32'd1;
        op2   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(s_edge, res, lat, busy_ok);
        check("repulse result", res, 32'hFFFF_FFEB);
        check("repulse latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;
        expect_quiet("repulse no extra done", 5);

        // START in the DONE cycle must be ignored
        issue(3'd0, 32'd3, 32'd5, s_edge);
        wait_done(s_edge, res, lat, busy_ok);
        check("done-cycle op result", res, 32'd15);
        start = 1'b1;
        md_op = 3'd5;
        op1   = 32'd9;
        op2   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done-cycle start busy", 32'(busy), 32'd0);
        expect_quiet("done-cycle start no done", 4);
        check("done-cycle result kept", result, 32'd15);

        // Reset at iteration 10 aborts the operation
        issue(3'd0, 32'h0001_2345, 32'h0000_0777, s_edge);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort result", result, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_quiet("abort no done", 40);
        check("abort busy stays low", 32'(busy), 32'd0);

        run_vec('{"mul 6*7 after reset", 3'd0, 32'd6, 32'd7, 32'd42, 33});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
